// File: rtl/debounce_scheduler_if.sv
// Bundle of the board-facing inputs and user-facing debounced outputs of
// debounce_scheduler.
//   noisy      : raw asynchronous inputs, one per channel
//   debounced  : committed clean levels
//   rise/fall  : one-cycle pulses aligned with a debounced level change
//   busy       : shared stability timer is granted to a channel
//   active_ch  : granted channel index, 0 when idle
// master = the side that drives pins (board / testbench), slave = the debouncer.
interface debounce_scheduler_if #(
  parameter int N    = 4,
  parameter int CH_W = 2
);
  logic [N-1:0]    noisy;
  logic [N-1:0]    debounced;
  logic [N-1:0]    rise;
  logic [N-1:0]    fall;
  logic            busy;
  logic [CH_W-1:0] active_ch;

  modport master (
    output noisy,
    input  debounced, rise, fall, busy, active_ch
  );

  modport slave (
    input  noisy,
    output debounced, rise, fall, busy, active_ch
  );
endinterface

// File: rtl/debounce_scheduler.sv
// Debounces N noisy inputs with one shared stability timer. A round-robin
// arbiter grants the timer to one pending channel at a time; the new level is
// committed only if the synchronized input holds for FINAL_VALUE+1 cycles.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : debounce_scheduler_if.slave (noisy in; debounced, rise, fall,
//           busy, active_ch out)
//
// state  | meaning
// IDLE   | timer free; pick next pending channel after last_grant
// COUNT  | timer running for ch; abort if its input leaves target
// COMMIT | one cycle: write target to debounced[ch], fire edge pulse
module debounce_scheduler #(
  parameter int N           = 4,
  parameter int FINAL_VALUE = 19_999_999,
  parameter int TIMER_W     = 25,
  parameter int CH_W        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  debounce_scheduler_if.slave  bus
);

  if (64'(FINAL_VALUE) >= (64'd1 << TIMER_W)) begin : g_bad_timer_w
    $error("debounce_scheduler: FINAL_VALUE does not fit in TIMER_W bits");
  end
  if (CH_W != ((N > 1) ? $clog2(N) : 1)) begin : g_bad_ch_w
    $error("debounce_scheduler: CH_W must equal max(1, clog2(N))");
  end

  localparam logic [TIMER_W-1:0] FINAL_T = TIMER_W'(FINAL_VALUE);
  localparam logic [CH_W-1:0]    LAST_CH = CH_W'(N - 1);

  typedef enum logic [1:0] {IDLE, COUNT, COMMIT} state_t;

  state_t              state, state_next;
  logic [N-1:0]        sync_meta, sync, deb, rise_q, fall_q, pending;
  logic [TIMER_W-1:0]  timer, timer_next;
  logic [CH_W-1:0]     ch, ch_next, last_grant, last_grant_next;
  logic [CH_W-1:0]     grant_ch, scan;
  logic                target, target_next, grant_found, do_commit;

  assign pending = sync ^ deb;

  // Round-robin search starting just after last_grant, wrapping at N-1.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    scan        = last_grant;
    for (int k = 0; k < N; k++) begin
      if (scan == LAST_CH) scan = '0;
      else                 scan = scan + CH_W'(1);
      if (!grant_found && pending[scan]) begin
        grant_found = 1'b1;
        grant_ch    = scan;
      end
    end
  end

  always_comb begin
    state_next      = state;
    timer_next      = timer;
    ch_next         = ch;
    target_next     = target;
    last_grant_next = last_grant;
    do_commit       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          ch_next     = grant_ch;
          target_next = sync[grant_ch];
          timer_next  = '0;
          state_next  = COUNT;
        end
      end
      COUNT: begin
        if (sync[ch] != target) begin
          // Bounced: give the timer away so other channels are not starved.
          state_next      = IDLE;
          last_grant_next = ch;
          timer_next      = '0;
        end else if (timer == FINAL_T) begin
          state_next = COMMIT;
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      COMMIT: begin
        do_commit       = 1'b1;
        last_grant_next = ch;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta  <= '0;
      sync       <= '0;
      deb        <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      state      <= IDLE;
      timer      <= '0;
      ch         <= '0;
      target     <= 1'b0;
      last_grant <= LAST_CH;
    end else begin
      sync_meta  <= bus.noisy;
      sync       <= sync_meta;
      state      <= state_next;
      timer      <= timer_next;
      ch         <= ch_next;
      target     <= target_next;
      last_grant <= last_grant_next;
      rise_q     <= '0;
      fall_q     <= '0;
      if (do_commit) begin
        deb[ch]    <= target;
        rise_q[ch] <= target & ~deb[ch];
        fall_q[ch] <= ~target & deb[ch];
      end
    end
  end

  assign bus.debounced = deb;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.busy      = (state != IDLE);
  assign bus.active_ch = (state == IDLE) ? '0 : ch;

endmodule
